// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory-access stage: load/store encodings,
// FSM state encoding and small helpers for access size, alignment and lanes.
package memory_access_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [2:0] LB      = 3'd0;
  localparam logic [2:0] LH      = 3'd1;
  localparam logic [2:0] LW      = 3'd2;
  localparam logic [2:0] LBU     = 3'd3;
  localparam logic [2:0] LHU     = 3'd4;
  localparam logic [2:0] NOTLOAD = 3'd7;

  localparam logic [1:0] SB       = 2'd0;
  localparam logic [1:0] SH       = 2'd1;
  localparam logic [1:0] SW       = 2'd2;
  localparam logic [1:0] NOTSTORE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_t;

  // Access width of a load or store; non-memory ops report word size.
  function automatic size_t access_size(input logic [2:0] ld, input logic [1:0] st);
    size_t sz;
    sz = SIZE_W;
    if (ld == LB || ld == LBU || (ld == NOTLOAD && st == SB)) sz = SIZE_B;
    else if (ld == LH || ld == LHU || (ld == NOTLOAD && st == SH)) sz = SIZE_H;
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
    logic mis;
    case (sz)
      SIZE_H:  mis = off[0];
      SIZE_W:  mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte offset with the low bits cleared that a given size cannot use.
  function automatic logic [1:0] align_offset(input size_t sz, input logic [1:0] off);
    logic [1:0] aligned;
    case (sz)
      SIZE_B:  aligned = off;
      SIZE_H:  aligned = {off[1], 1'b0};
      default: aligned = 2'b00;
    endcase
    return aligned;
  endfunction

  function automatic logic [3:0] byte_enable(input size_t sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      SIZE_B:  be = 4'b0001 << off;
      SIZE_H:  be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the byte enables pick the slot.
  function automatic logic [31:0] lane_data(input size_t sz, input logic [31:0] d);
    logic [31:0] lanes;
    case (sz)
      SIZE_B:  lanes = {4{d[7:0]}};
      SIZE_H:  lanes = {2{d[15:0]}};
      default: lanes = d;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to the load type.
module load_extend
  import memory_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  load_type,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension to a full word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'd0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues one data-memory request per load or
// store, stalls upstream until the bus acknowledges, then hands the result
// to writeback. Non-memory ops and trapped misaligned ops pass in one cycle.
module memory_access
  import memory_access_pkg::*;
#(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2E,
  input  logic        write_regE,
  input  logic [2:0]  info_loadE,
  input  logic [1:0]  info_storeE,
  input  logic [4:0]  dstreg_addrE,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [31:0] forward_data_writemem,
  output logic        write_regM,
  output logic [4:0]  dstreg_addrM,
  output logic [31:0] wb_data,
  output logic        misaligned
);

  state_t      state, state_next;
  size_t       size_in;
  logic        is_load_in, is_store_in, mem_op, misalign_in, issue;
  logic [1:0]  offset_in;

  logic [2:0]  load_type_q;
  logic [1:0]  offset_q;
  logic        is_load_q, we_q, write_reg_q, kill_q;
  logic [4:0]  dst_q;
  logic [31:0] rdata_q, load_data;

  assign is_load_in  = (info_loadE != NOTLOAD);
  assign is_store_in = (info_storeE != NOTSTORE);
  assign mem_op      = is_load_in || is_store_in;
  assign size_in     = access_size(info_loadE, info_storeE);
  assign offset_in   = align_offset(size_in, alu_result[1:0]);
  assign misalign_in = MISALIGN_CHECK && mem_op && is_misaligned(size_in, alu_result[1:0]);
  assign issue       = (state == IDLE) && mem_op && !flush && !misalign_in;

  assign forward_data_writemem = alu_result;

  load_extend u_load_extend (
    .rdata     (rdata_q),
    .load_type (load_type_q),
    .offset    (offset_q),
    .data      (load_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: one issue, wait for ack, one cycle to publish the result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = issue ? BUSY : IDLE;
      BUSY:    state_next = dmem_ack ? DONE : BUSY;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus strobes and stall; the request drops as soon as the FSM leaves BUSY.
  always_comb begin
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: stall = issue;
      BUSY: begin
        dmem_req = 1'b1;
        dmem_we  = we_q;
        stall    = !dmem_ack;
      end
      default: stall = 1'b0;
    endcase
  end

  // Capture the transaction at issue, the read data at ack, and any flush
  // that arrives while the bus is still busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      we_q        <= FALSE;
      is_load_q   <= FALSE;
      load_type_q <= NOTLOAD;
      offset_q    <= '0;
      write_reg_q <= FALSE;
      dst_q       <= '0;
      kill_q      <= FALSE;
      rdata_q     <= '0;
    end else if (issue) begin
      dmem_addr   <= {alu_result[31:2], 2'b00};
      dmem_be     <= byte_enable(size_in, offset_in);
      dmem_wdata  <= lane_data(size_in, rs2E);
      we_q        <= is_store_in;
      is_load_q   <= is_load_in;
      load_type_q <= info_loadE;
      offset_q    <= offset_in;
      write_reg_q <= write_regE;
      dst_q       <= dstreg_addrE;
      kill_q      <= FALSE;
    end else if (state == BUSY) begin
      if (flush)    kill_q  <= TRUE;
      if (dmem_ack) rdata_q <= dmem_rdata;
    end
  end

  // Writeback registers: load directly in IDLE unless a request is issued,
  // load the memory result in DONE, otherwise hold; misaligned is a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_regM   <= FALSE;
      dstreg_addrM <= '0;
      wb_data      <= '0;
      misaligned   <= FALSE;
    end else begin
      misaligned <= FALSE;
      if (state == IDLE && !issue) begin
        wb_data <= alu_result;
        if (flush) begin
          write_regM   <= FALSE;
          dstreg_addrM <= '0;
        end else if (misalign_in) begin
          write_regM   <= FALSE;
          dstreg_addrM <= dstreg_addrE;
          misaligned   <= TRUE;
        end else begin
          write_regM   <= write_regE;
          dstreg_addrM <= dstreg_addrE;
        end
      end else if (state == DONE) begin
        write_regM   <= write_reg_q && is_load_q && !kill_q;
        dstreg_addrM <= kill_q ? 5'd0 : dst_q;
        wb_data      <= (is_load_q && !kill_q) ? load_data : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a table of single-cycle vectors followed
// by hand-written multi-cycle bus sequences.
module tb_memory_access;
  import memory_access_pkg::*;

  logic        clk, rst_n;
  logic [31:0] alu_result, rs2E, dmem_rdata;
  logic        write_regE, flush, dmem_ack;
  logic [2:0]  info_loadE;
  logic [1:0]  info_storeE;
  logic [4:0]  dstreg_addrE;
  logic        dmem_req, dmem_we, stall, write_regM, misaligned;
  logic [31:0] dmem_addr, dmem_wdata, forward_data_writemem, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  dstreg_addrM;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] alu;
    logic        wr;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [4:0]  dst;
    logic        fl;
    logic        ack;
    logic [31:0] exp_wb;
    logic        exp_wr;
    logic [4:0]  exp_dst;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    int          stall_cycles;
    int          req_cycles;
    int          acks;
    int          latency;
    int          unstable;
    int          fwd_bad;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        timeout;
  } mem_result_t;

  vec_t        vecs[8];
  mem_result_t r;

  memory_access #(.MISALIGN_CHECK(1'b1)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .alu_result            (alu_result),
    .rs2E                  (rs2E),
    .write_regE            (write_regE),
    .info_loadE            (info_loadE),
    .info_storeE           (info_storeE),
    .dstreg_addrE          (dstreg_addrE),
    .flush                 (flush),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_be               (dmem_be),
    .dmem_rdata            (dmem_rdata),
    .dmem_ack              (dmem_ack),
    .stall                 (stall),
    .forward_data_writemem (forward_data_writemem),
    .write_regM            (write_regM),
    .dstreg_addrM          (dstreg_addrM),
    .wb_data               (wb_data),
    .misaligned            (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic set_nop();
    alu_result   = 32'd0;
    rs2E         = 32'd0;
    write_regE   = 1'b0;
    info_loadE   = NOTLOAD;
    info_storeE  = NOTSTORE;
    dstreg_addrE = 5'd0;
    flush        = 1'b0;
    dmem_ack     = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    alu_result   = v.alu;
    rs2E         = 32'hCAFE_F00D;
    write_regE   = v.wr;
    info_loadE   = v.ld;
    info_storeE  = v.st;
    dstreg_addrE = v.dst;
    flush        = v.fl;
    dmem_ack     = v.ack;
    dmem_rdata   = 32'h1111_2222;
  endtask

  task automatic check_output(input int i, input vec_t v);
    check($sformatf("vec%0d wb_data", i), wb_data, v.exp_wb);
    check($sformatf("vec%0d write_regM", i), 32'(write_regM), 32'(v.exp_wr));
    check($sformatf("vec%0d dstreg_addrM", i), 32'(dstreg_addrM), 32'(v.exp_dst));
    check($sformatf("vec%0d misaligned", i), 32'(misaligned), 32'(v.exp_mis));
  endtask

  // Presents one memory op at posedge+1, plays the bus side, and returns at
  // posedge+1 just after the DONE cycle with NOP inputs presented.
  task automatic run_mem(input logic [31:0] alu, input logic [31:0] rs2, input logic wr,
                         input logic [2:0] ld, input logic [1:0] st, input logic [4:0] dst,
                         input int waits, input logic [31:0] rdata, input int flush_at,
                         output mem_result_t res);
    int cycles;
    bit in_done, finished, ack_prev;
    res = '{default: 0};
    alu_result   = alu;
    rs2E         = rs2;
    write_regE   = wr;
    info_loadE   = ld;
    info_storeE  = st;
    dstreg_addrE = dst;
    cycles   = 0;
    in_done  = 0;
    finished = 0;
    while (!finished && cycles < 40) begin
      dmem_ack   = 1'b0;
      flush      = 1'b0;
      dmem_rdata = 32'hDEAD_0000;
      if (in_done) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5A5A_5A5A;
      end else if (dmem_req) begin
        if (res.req_cycles == waits) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
        if (res.req_cycles == flush_at) flush = 1'b1;
      end
      #4;
      if (stall) res.stall_cycles++;
      if (forward_data_writemem !== alu) res.fwd_bad++;
      if (dmem_req) begin
        if (res.req_cycles == 0) begin
          res.addr  = dmem_addr;
          res.wdata = dmem_wdata;
          res.be    = dmem_be;
          res.we    = dmem_we;
        end else if (dmem_addr !== res.addr || dmem_wdata !== res.wdata ||
                     dmem_be !== res.be || dmem_we !== res.we) begin
          res.unstable++;
        end
        res.req_cycles++;
        if (dmem_ack) res.acks++;
      end
      ack_prev = dmem_req && dmem_ack;
      @(posedge clk);
      #1;
      cycles++;
      if (in_done) finished = 1;
      else if (ack_prev) in_done = 1;
    end
    res.latency = cycles;
    res.timeout = !finished;
    set_nop();
  endtask

  initial begin
    vecs[0] = '{32'h1234_5678, 1'b0, NOTLOAD, NOTSTORE, 5'd0,  1'b0, 1'b1, 32'h1234_5678, 1'b0, 5'd0,  1'b0};
    vecs[1] = '{32'h0000_0101, 1'b1, LW,      NOTSTORE, 5'd7,  1'b0, 1'b0, 32'h0000_0101, 1'b0, 5'd7,  1'b1};
    vecs[2] = '{32'hDEAD_BEEF, 1'b1, NOTLOAD, NOTSTORE, 5'd31, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 5'd31, 1'b0};
    vecs[3] = '{32'h0000_0203, 1'b1, LH,      NOTSTORE, 5'd3,  1'b0, 1'b0, 32'h0000_0203, 1'b0, 5'd3,  1'b1};
    vecs[4] = '{32'h0000_0006, 1'b0, NOTLOAD, SW,       5'd0,  1'b0, 1'b0, 32'h0000_0006, 1'b0, 5'd0,  1'b1};
    vecs[5] = '{32'h0000_0100, 1'b1, LW,      NOTSTORE, 5'd4,  1'b1, 1'b0, 32'h0000_0100, 1'b0, 5'd0,  1'b0};
    vecs[6] = '{32'h0000_0101, 1'b1, LH,      NOTSTORE, 5'd4,  1'b1, 1'b0, 32'h0000_0101, 1'b0, 5'd0,  1'b0};
    vecs[7] = '{32'h0000_0055, 1'b1, NOTLOAD, NOTSTORE, 5'd5,  1'b0, 1'b0, 32'h0000_0055, 1'b1, 5'd5,  1'b0};

    rst_n      = 1'b0;
    dmem_rdata = 32'd0;
    set_nop();
    #11;
    check("reset dmem_req", 32'(dmem_req), 32'd0);
    check("reset dmem_we", 32'(dmem_we), 32'd0);
    check("reset dmem_be", 32'(dmem_be), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset write_regM", 32'(write_regM), 32'd0);
    check("reset misaligned", 32'(misaligned), 32'd0);
    check("reset dstreg_addrM", 32'(dstreg_addrM), 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    check("reset dmem_addr", dmem_addr, 32'd0);
    check("reset dmem_wdata", dmem_wdata, 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle vectors: non-memory ops, trapped misalignment, flushed ops.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i]);
      #4;
      check($sformatf("vec%0d stall", i), 32'(stall), 32'd0);
      check($sformatf("vec%0d dmem_req", i), 32'(dmem_req), 32'd0);
      check($sformatf("vec%0d forward", i), forward_data_writemem, vecs[i].alu);
      @(posedge clk);
      #1;
      check_output(i, vecs[i]);
    end

    // LHU right behind the ADD 0x55 of the last vector.
    run_mem(32'h0000_0000, 32'd0, 1'b1, LHU, NOTSTORE, 5'd9, 0, 32'h0000_8001, -1, r);
    check("lhu timeout", 32'(r.timeout), 32'd0);
    check("lhu wb_data", wb_data, 32'h0000_8001);
    check("lhu write_regM", 32'(write_regM), 32'd1);
    check("lhu dstreg_addrM", 32'(dstreg_addrM), 32'd9);
    check("lhu latency", 32'(r.latency), 32'd3);
    check("lhu be", 32'(r.be), 32'h3);
    check("lhu forward", 32'(r.fwd_bad), 32'd0);

    // LB at 0x103 with two wait states, issued back to back.
    run_mem(32'h0000_0103, 32'd0, 1'b1, LB, NOTSTORE, 5'd10, 2, 32'h80FF_1234, -1, r);
    check("lb timeout", 32'(r.timeout), 32'd0);
    check("lb wb_data", wb_data, 32'hFFFF_FF80);
    check("lb write_regM", 32'(write_regM), 32'd1);
    check("lb dstreg_addrM", 32'(dstreg_addrM), 32'd10);
    check("lb stall cycles", 32'(r.stall_cycles), 32'd3);
    check("lb latency", 32'(r.latency), 32'd5);
    check("lb req cycles", 32'(r.req_cycles), 32'd3);
    check("lb addr", r.addr, 32'h0000_0100);
    check("lb be", 32'(r.be), 32'h8);
    check("lb we", 32'(r.we), 32'd0);
    check("lb stable", 32'(r.unstable), 32'd0);

    // SH at 0x202: upper halfword lanes, data replicated.
    run_mem(32'h0000_0202, 32'h0000_ABCD, 1'b0, NOTLOAD, SH, 5'd0, 1, 32'd0, -1, r);
    check("sh timeout", 32'(r.timeout), 32'd0);
    check("sh be", 32'(r.be), 32'hC);
    check("sh wdata", r.wdata, 32'hABCD_ABCD);
    check("sh we", 32'(r.we), 32'd1);
    check("sh addr", r.addr, 32'h0000_0200);
    check("sh write_regM", 32'(write_regM), 32'd0);
    check("sh latency", 32'(r.latency), 32'd4);
    check("sh stable", 32'(r.unstable), 32'd0);

    // SB at 0x301: single byte lane 1.
    run_mem(32'h0000_0301, 32'h1234_5678, 1'b0, NOTLOAD, SB, 5'd0, 0, 32'd0, -1, r);
    check("sb be", 32'(r.be), 32'h2);
    check("sb wdata", r.wdata, 32'h7878_7878);
    check("sb latency", 32'(r.latency), 32'd3);

    // LH from the upper halfword, sign-extended.
    run_mem(32'h0000_0006, 32'd0, 1'b1, LH, NOTSTORE, 5'd11, 0, 32'h8001_7FFF, -1, r);
    check("lh wb_data", wb_data, 32'hFFFF_8001);
    check("lh be", 32'(r.be), 32'hC);

    // LBU from byte 1 with three wait states; ack in DONE must be ignored.
    run_mem(32'h0000_0001, 32'd0, 1'b1, LBU, NOTSTORE, 5'd12, 3, 32'h0000_F000, -1, r);
    check("lbu wb_data", wb_data, 32'h0000_00F0);
    check("lbu latency", 32'(r.latency), 32'd6);
    check("lbu stall cycles", 32'(r.stall_cycles), 32'd4);

    // Flush during BUSY: the bus cycle completes once, result discarded.
    run_mem(32'h0000_0400, 32'd0, 1'b1, LW, NOTSTORE, 5'd13, 2, 32'h7777_7777, 0, r);
    check("flush timeout", 32'(r.timeout), 32'd0);
    check("flush acks", 32'(r.acks), 32'd1);
    check("flush req cycles", 32'(r.req_cycles), 32'd3);
    check("flush write_regM", 32'(write_regM), 32'd0);
    check("flush dstreg_addrM", 32'(dstreg_addrM), 32'd0);
    #4;
    check("post-flush dmem_req", 32'(dmem_req), 32'd0);
    @(posedge clk);
    #1;

    // Reset asserted in the middle of a BUSY cycle.
    alu_result   = 32'h0000_0500;
    write_regE   = 1'b1;
    info_loadE   = LW;
    dstreg_addrE = 5'd6;
    @(posedge clk);
    #1;
    check("busy dmem_req", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    set_nop();
    #1;
    check("mid-busy reset dmem_req", 32'(dmem_req), 32'd0);
    check("mid-busy reset stall", 32'(stall), 32'd0);
    check("mid-busy reset wb_data", wb_data, 32'd0);
    check("mid-busy reset dmem_addr", dmem_addr, 32'd0);
    check("mid-busy reset dmem_be", 32'(dmem_be), 32'd0);
    check("mid-busy reset write_regM", 32'(write_regM), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after reset dmem_req", 32'(dmem_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter MISALIGN_CHECK, default 1: when 1, misaligned accesses are trapped; when 0, low address bits are ignored (word/halfword forced aligned).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 alu_result  input  32  execute-stage result: memory address for load/store, else writeback value.
REQ-005 rs2E  input  32  store data.
REQ-006 write_regE, info_loadE[3], info_storeE[2], dstreg_addrE[5]  input  execute-stage control.
REQ-007 flush  input  1  kill the instruction currently presented.
REQ-008 dmem_req, dmem_we  output  1  memory request / write strobe.
REQ-009 dmem_addr  output  32  word-aligned address (bits [1:0] = 0).
REQ-010 dmem_wdata  output  32 and dmem_be  output  4  lane-aligned store data and byte enables.
REQ-011 dmem_rdata  input  32 and dmem_ack  input  1  read data, valid in the ack cycle; ack completes a request.
REQ-012 stall  output  1  upstream SHALL hold all inputs while high.
REQ-013 forward_data_writemem  output  32  combinational copy of alu_result.
REQ-014 write_regM  output  1, dstreg_addrM  output  5, wb_data  output  32, misaligned  output  1  registered writeback-stage outputs.

Function
REQ-015 FSM states: IDLE, BUSY, DONE.
REQ-016 mem_op = (info_loadE != NOTLOAD) or (info_storeE != NOTSTORE); no op has both set.
REQ-017 IDLE with no mem_op, or with flush: the registered outputs load in one cycle; stall = 0; no request.
REQ-018 IDLE with a valid, aligned mem_op and no flush: capture address, byte enables, lane data and load type; go BUSY; stall = 1 in that cycle.
REQ-019 BUSY: dmem_req = 1 with the captured, stable values; stall = !dmem_ack; on ack, capture dmem_rdata and go DONE.
REQ-020 DONE: stall = 0; output registers load (load = extended captured data, store = write_regM 0); go IDLE.
REQ-021 Latency from presentation to output: non-memory op 1 cycle; memory op 3 + N cycles, where N is the number of BUSY cycles without ack.
REQ-022 Loads: LB/LBU select the byte at addr[1:0]; LH/LHU select the halfword at addr[1]; LW takes the whole word; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-023 Stores: SB sets be = 0001 << addr[1:0] and replicates the byte on all lanes; SH sets be = 0011 or 1100 and replicates the halfword; SW sets be = 1111.
REQ-024 Misalignment (halfword with addr[0] = 1, word with addr[1:0] != 0) and MISALIGN_CHECK = 1: no request; misaligned = 1 for exactly one cycle; write_regM = 0; 1-cycle latency.
REQ-025 Flush while BUSY: the bus transaction completes (it is never abandoned); the result is discarded (DONE outputs write_regM 0, dstreg_addrM 0).
REQ-026 Ack while IDLE or DONE is ignored.
REQ-027 Back-to-back memory ops: DONE → IDLE → next issue; no request is re-issued for the held instruction.

Reset
REQ-028 On rst_n low, asynchronously: state IDLE; dmem_req, dmem_we, dmem_be, stall-source state, write_regM, misaligned = 0; dstreg_addrM = 0; wb_data, dmem_addr, dmem_wdata = 0.
REQ-029 Reset mid-BUSY drops the request immediately; the memory side SHALL tolerate an abandoned request.

Structure
REQ-030 The load/store encodings (LB, LH, LW, LBU, LHU, NOTLOAD; SB, SH, SW, NOTSTORE), TRUE/FALSE and the FSM state encodings live in the shared define header used by execute.
REQ-031 One sub-module, load_extend, SHALL implement lane selection and extension combinationally.

Verification
REQ-032 LB at address 0x103, rdata 0x80FF_1234, ack after 2 wait cycles → wb_data 0xFFFF_FF80, write_regM 1, stall high for 3 cycles, latency 5.
REQ-033 SH at address 0x202, rs2E 0x0000_ABCD → dmem_be 1100, dmem_wdata 0xABCD_ABCD, dmem_we 1, write_regM 0.
REQ-034 LW at address 0x101, MISALIGN_CHECK 1 → no dmem_req, misaligned pulses one cycle, write_regM 0.
REQ-035 Flush asserted while BUSY on an LW, then ack → exactly one bus request completes, write_regM 0 after DONE.
REQ-036 ADD result 0x55 followed by LHU at address 0x0, rdata 0x0000_8001 → wb_data 0x55 after 1 cycle, then 0x0000_8001; forward_data_writemem tracks alu_result every cycle.
REQ-037 rst_n low during BUSY → dmem_req drops asynchronously, state IDLE, outputs at reset values.
